// File: rtl/shared_counters_pkg.sv
// Shared types and defaults for the shared_counters command scheduler:
// command encodings, scheduler states and timeout defaults.
package shared_counters_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int N_DEF        = 10;
  localparam int G_DEF        = 4;
  localparam int ALLOC_TO_DEF = 8;
  localparam int READ_TO_DEF  = 16;

  typedef enum logic [2:0] {
    CMD_IDLE    = 3'b000,
    CMD_INC     = 3'b001,
    CMD_NEW     = 3'b010,
    CMD_DEALLOC = 3'b011,
    CMD_LOAD    = 3'b100,
    CMD_READ    = 3'b101
  } sc_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ALLOC,
    ST_READ,
    ST_RESP
  } sched_state_e;

  // Encodings 000, 110 and 111 are never forwarded to shared_counters.
  function automatic logic sc_cmd_legal(input logic [2:0] cmd);
    logic legal;
    case (cmd)
      CMD_INC, CMD_NEW, CMD_DEALLOC, CMD_LOAD, CMD_READ: legal = 1'b1;
      default:                                           legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/shared_counters_sched_if.sv
// Requester-side handshake plus shared_counters command port, bundled for the scheduler.
// The slave modport is the scheduler; master is the requester/shared_counters side.
interface shared_counters_sched_if #(
  parameter int N_REQ = 4,
  parameter int G     = 4,
  parameter int ID_W  = 4
);
  import shared_counters_pkg::*;

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [3*N_REQ-1:0]       req_cmd;
  logic [ID_W*N_REQ-1:0]    req_id;
  logic [32*N_REQ-1:0]      req_size;
  logic [64*N_REQ-1:0]      req_load_data;

  logic [2:0]               sc_command_in;
  logic [ID_W-1:0]          sc_id;
  logic [31:0]              sc_new_counter_size;
  logic [63:0]              sc_load_data_in;
  logic                     sc_valid_load_data;
  logic [ID_W:0]            sc_allocation_id;
  logic                     sc_valid_allocation_id;
  logic [G-1:0]             sc_rdata_out;
  logic                     sc_valid_data_out;
  logic                     sc_last;

  logic                     rsp_valid;
  logic [$clog2(N_REQ)-1:0] rsp_owner;
  logic [G-1:0]             rsp_data;
  logic                     rsp_last;
  logic [ID_W:0]            rsp_alloc_id;
  logic                     rsp_err;

  modport slave (
    input  req_valid, req_cmd, req_id, req_size, req_load_data,
    input  sc_allocation_id, sc_valid_allocation_id, sc_rdata_out, sc_valid_data_out, sc_last,
    output req_ready,
    output sc_command_in, sc_id, sc_new_counter_size, sc_load_data_in, sc_valid_load_data,
    output rsp_valid, rsp_owner, rsp_data, rsp_last, rsp_alloc_id, rsp_err
  );

  modport master (
    output req_valid, req_cmd, req_id, req_size, req_load_data,
    output sc_allocation_id, sc_valid_allocation_id, sc_rdata_out, sc_valid_data_out, sc_last,
    input  req_ready,
    input  sc_command_in, sc_id, sc_new_counter_size, sc_load_data_in, sc_valid_load_data,
    input  rsp_valid, rsp_owner, rsp_data, rsp_last, rsp_alloc_id, rsp_err
  );

endinterface

// File: rtl/shared_counters_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr.
// The parent owns the pointer register and updates it with the grant index.
module rr_arbiter
  import shared_counters_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_idx,
  output logic             grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (enable) begin
      for (int i = 1; i <= N_REQ; i++) begin
        idx = (int'(ptr) + i) % N_REQ;
        if (!grant_any && req[idx]) begin
          grant[idx] = 1'b1;
          grant_idx  = PW'(idx);
          grant_any  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_counters_sched.sv
// Round-robin command scheduler sharing one shared_counters port between N_REQ requesters.
// Owns the port for the whole command (allocation wait, read burst) and routes responses back.
module shared_counters_sched
  import shared_counters_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int N        = N_DEF,
  parameter int G        = G_DEF,
  parameter int ID_W     = $clog2(N),
  parameter int ALLOC_TO = ALLOC_TO_DEF,
  parameter int READ_TO  = READ_TO_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  shared_counters_sched_if.slave  bus
);

  localparam int PW = $clog2(N_REQ);

  sched_state_e     state, state_nx;
  logic [PW-1:0]    ptr, owner, win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic             win_any;
  logic [2:0]       cmd_q;
  logic             err_q;
  logic [15:0]      timer;
  logic             alloc_timeout, read_timeout;

  logic [2:0]       win_cmd;
  logic [ID_W-1:0]  win_id;
  logic [31:0]      win_size;
  logic [63:0]      win_data;
  logic             win_err;

  logic [2:0]       sc_cmd_r, sc_cmd_d;
  logic [ID_W-1:0]  sc_id_r, sc_id_d;
  logic [31:0]      sc_size_r, sc_size_d;
  logic [63:0]      sc_load_r, sc_load_d;
  logic             sc_vload_r, sc_vload_d;
  logic             rsp_valid_d, rsp_last_d, rsp_err_d;
  logic [G-1:0]     rsp_data_d;
  logic [ID_W:0]    rsp_alloc_d;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .enable    (state == ST_IDLE),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .grant_any (win_any)
  );

  always_comb begin
    win_cmd  = bus.req_cmd[win_idx*3 +: 3];
    win_id   = bus.req_id[win_idx*ID_W +: ID_W];
    win_size = bus.req_size[win_idx*32 +: 32];
    win_data = bus.req_load_data[win_idx*64 +: 64];
    // new_counter carries no target id, so only other commands are range-checked
    win_err  = !sc_cmd_legal(win_cmd) || (win_cmd != CMD_NEW && 32'(win_id) >= N);
  end

  assign alloc_timeout = (timer == 16'(ALLOC_TO - 1));
  assign read_timeout  = (timer == 16'(READ_TO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:       if (win_any) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        if (err_q)                 state_nx = ST_RESP;
        else if (cmd_q == CMD_NEW) state_nx = ST_WAIT_ALLOC;
        else if (cmd_q == CMD_READ) state_nx = ST_READ;
        else                       state_nx = ST_RESP;
      end
      ST_WAIT_ALLOC: if (bus.sc_valid_allocation_id || alloc_timeout) state_nx = ST_IDLE;
      ST_READ:       if ((bus.sc_valid_data_out && bus.sc_last) || read_timeout) state_nx = ST_IDLE;
      ST_RESP:       state_nx = ST_IDLE;
      default:       state_nx = ST_IDLE;
    endcase
  end

  // Computes the next value of every registered sc_* and rsp_* output.
  always_comb begin
    sc_cmd_d    = CMD_IDLE;
    sc_id_d     = '0;
    sc_size_d   = '0;
    sc_load_d   = '0;
    sc_vload_d  = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_last_d  = 1'b0;
    rsp_alloc_d = '0;
    rsp_err_d   = 1'b0;
    bus.req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (rst) bus.req_ready = win_onehot;
        if (win_any && !win_err) begin
          sc_cmd_d = win_cmd;
          sc_id_d  = win_id;
          if (win_cmd == CMD_NEW) sc_size_d = win_size;
          if (win_cmd == CMD_LOAD) begin
            sc_load_d  = win_data;
            sc_vload_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (err_q || !(cmd_q inside {CMD_NEW, CMD_READ})) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_err_d   = err_q;
        end else if (cmd_q == CMD_READ) begin
          sc_cmd_d = CMD_READ;
          sc_id_d  = sc_id_r;
        end
      end
      ST_WAIT_ALLOC: begin
        if (bus.sc_valid_allocation_id) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_alloc_d = bus.sc_allocation_id;
        end else if (alloc_timeout) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ST_READ: begin
        if (bus.sc_valid_data_out && bus.sc_last) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.sc_rdata_out;
          rsp_last_d  = 1'b1;
        end else if (read_timeout) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.sc_valid_data_out ? bus.sc_rdata_out : '0;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          sc_cmd_d = CMD_READ;
          sc_id_d  = sc_id_r;
          if (bus.sc_valid_data_out) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.sc_rdata_out;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= PW'(N_REQ - 1);
      owner <= '0;
      cmd_q <= CMD_IDLE;
      err_q <= 1'b0;
      timer <= '0;
    end else begin
      if (state == ST_IDLE && win_any) begin
        ptr   <= win_idx;
        owner <= win_idx;
        cmd_q <= win_cmd;
        err_q <= win_err;
      end
      timer <= (state == ST_WAIT_ALLOC || state == ST_READ) ? timer + 16'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_cmd_r         <= CMD_IDLE;
      sc_id_r          <= '0;
      sc_size_r        <= '0;
      sc_load_r        <= '0;
      sc_vload_r       <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_owner    <= '0;
      bus.rsp_data     <= '0;
      bus.rsp_last     <= 1'b0;
      bus.rsp_alloc_id <= '0;
      bus.rsp_err      <= 1'b0;
    end else begin
      sc_cmd_r         <= sc_cmd_d;
      sc_id_r          <= sc_id_d;
      sc_size_r        <= sc_size_d;
      sc_load_r        <= sc_load_d;
      sc_vload_r       <= sc_vload_d;
      bus.rsp_valid    <= rsp_valid_d;
      bus.rsp_owner    <= rsp_valid_d ? owner : '0;
      bus.rsp_data     <= rsp_data_d;
      bus.rsp_last     <= rsp_last_d;
      bus.rsp_alloc_id <= rsp_alloc_d;
      bus.rsp_err      <= rsp_err_d;
    end
  end

  assign bus.sc_command_in       = sc_cmd_r;
  assign bus.sc_id               = sc_id_r;
  assign bus.sc_new_counter_size = sc_size_r;
  assign bus.sc_load_data_in     = sc_load_r;
  assign bus.sc_valid_load_data  = sc_vload_r;

endmodule

// File: doc/shared_counters_sched.md
Name: shared_counters_sched

Overview:
- Command scheduler sharing one shared_counters instance between N_REQ requesters.
- Requesters use a valid/ready handshake; the scheduler picks one by round-robin and drives the shared_counters command port for the full command duration.
- Holds the port for multi-cycle operations: allocation wait, and the read burst up to last.
- Routes allocation ids, read beats and completion/error status back to the owning requester.

Parameters:
N_REQ, 4, number of requesters
N, 10, counter segments in shared_counters
G, 4, segment width / read beat width
ID_W, $clog2(N), counter id width
ALLOC_TO, 8, max cycles waiting for valid_allocation_id
READ_TO, 16, max cycles waiting for read last beat

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
req_valid  in  N_REQ  request valid per requester
req_ready  out  N_REQ  one-hot accept pulse
req_cmd  in  3*N_REQ  per-requester command (001 inc, 010 new, 011 dealloc, 100 load, 101 read)
req_id  in  ID_W*N_REQ  target counter id
req_size  in  32*N_REQ  new_counter size
req_load_data  in  64*N_REQ  load payload
sc_command_in  out  3  to shared_counters command_in
sc_id  out  ID_W  to shared_counters id
sc_new_counter_size  out  32  to shared_counters
sc_load_data_in  out  64  to shared_counters
sc_valid_load_data  out  1  to shared_counters
sc_allocation_id  in  ID_W+1  from shared_counters
sc_valid_allocation_id  in  1  from shared_counters
sc_rdata_out  in  G  from shared_counters
sc_valid_data_out  in  1  from shared_counters
sc_last  in  1  from shared_counters
rsp_valid  out  1  response strobe
rsp_owner  out  $clog2(N_REQ)  requester index of the response
rsp_data  out  G  read beat
rsp_last  out  1  final response of the command
rsp_alloc_id  out  ID_W+1  allocated id (new_counter only)
rsp_err  out  1  illegal command, id out of range, or timeout

Behaviour:
- Reset (rst=0, async):
  - All outputs are 0; sc_command_in = 000 (idle).
  - FSM returns to IDLE; RR pointer = N_REQ-1, so requester 0 has first priority.
  - Any in-flight command is aborted silently; no response is issued.
- FSM states: IDLE, ISSUE, WAIT_ALLOC, READ, RESP.
- IDLE:
  - sc_command_in = 000.
  - If any req_valid, the winner is the first set bit starting at pointer+1 (mod N_REQ).
  - req_ready[winner]=1 for this cycle only; request is captured; pointer = winner; next state ISSUE.
  - req_ready is asserted only in IDLE, so at most one bit is set per cycle.
- Handshake rules:
  - Requester holds req_valid and its fields stable until ready.
  - Dropping req_valid before ready withdraws the request; this is legal.
- ISSUE (one cycle; all sc_* outputs registered):
  - Illegal cmd (000, 110, 111) or id >= N (except new_counter): nothing is driven (command 000); go to RESP with err=1.
  - Increment, dealloc: drive cmd and id for exactly one cycle; go to RESP.
  - Load: additionally drive sc_load_data_in and sc_valid_load_data=1 for this cycle only; go to RESP.
  - New_counter: drive 010 and size for one cycle; go to WAIT_ALLOC.
  - Read: drive 101 and id; go to READ.
- WAIT_ALLOC:
  - sc_command_in = 000, size = 0.
  - On sc_valid_allocation_id: rsp_alloc_id = sc_allocation_id, rsp_last=1, err=0; go to IDLE.
  - After ALLOC_TO cycles with no valid: rsp with err=1, last=1; go to IDLE.
- READ:
  - Hold 101 and id.
  - Each sc_valid_data_out produces one rsp_valid the next cycle, carrying rsp_data = sc_rdata_out and rsp_last = sc_last.
  - On sc_last: drop to 000 the next cycle; go to IDLE.
  - After READ_TO cycles without last: drop command; rsp with last=1, err=1.
- RESP: single-cycle completion; rsp_valid=1, last=1, err as decided in ISSUE; go to IDLE.
- Latency: with accept in cycle T, the sc command appears in T+1 and the single-cycle completion rsp in T+2. Peak throughput is one single-cycle command every 3 cycles.
- rsp_owner equals the captured winner for every response of a command.
- rsp_valid is a one-cycle pulse per beat or completion. There is no backpressure on rsp.

Decomposition:
- shared_counters_pkg holds:
  - sc_cmd_e enum (IDLE=000, INC=001, NEW=010, DEALLOC=011, LOAD=100, READ=101)
  - sched_state_e
  - ALLOC_TO and READ_TO defaults
- Sub-module rr_arbiter (params N_REQ):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational, plus pointer update in the parent.

Test Plan:
- Reset/priority: reset, then req_valid=1111 all INC ids 0..3 → ready grants 0,1,2,3 in order; sc_command_in=001 with sc_id 0,1,2,3; four rsp with owners 0..3 and err=0.
- Allocation: req1 NEW size=3, shared_counters replies id=0 after 2 cycles → sc_command_in=010 for exactly 1 cycle; rsp_owner=1, rsp_alloc_id=0, last=1.
- Read burst: req2 READ id=0 on a counter of size 3 → sc_command_in=101 held; 3 rsp beats with last=0,0,1 carrying sc_rdata_out; command drops to 000 the cycle after last. A pending req0 is not granted until then.
- Load: req3 LOAD id=0, data=0xAAAA_AAAA_AAAA_AAAA → sc_valid_load_data=1 for one cycle with matching data; rsp err=0.
- Errors: req0 cmd=110 → no sc activity, rsp err=1. req0 INC id=12 → rsp err=1. NEW with no valid_allocation_id → rsp err=1 exactly ALLOC_TO cycles later.
- Reset mid-read: assert rst during READ beat 2 → sc_command_in=000 and rsp_valid=0 immediately; after release, requester 0 is granted first.
